umi_tx_serializer: RTL and testbench

//  Transmit-side stage directly downstream of the UMI packer. Captures one packed
//  PW-bit UMI packet per valid/ready handshake and emits it as NBEATS beats of OW

---
 rtl/umi_tx_serializer_pkg.sv | 20 ++
 rtl/umi_tx_serializer_if.sv | 31 +++
 rtl/umi_tx_serializer_beat_counter.sv | 31 +++
 rtl/umi_tx_serializer.sv | 95 +++++++++
 tb/tb_umi_tx_serializer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/umi_tx_serializer_pkg.sv
// Shared definitions for the UMI transmit serializer: default widths,
// FSM state encoding and a helper for sizing the beat counter.
package umi_tx_serializer_pkg;

  localparam int AW_DEF = 64;
  localparam int PW_DEF = 4 * AW_DEF;
  localparam int OW_DEF = AW_DEF;

  // IDLE: nothing held. SEND: a packet is held and beats are being offered.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Beat counter width; a single-beat packet still gets a 1-bit counter.
  function automatic int cnt_width(input int nbeats);
    return (nbeats > 1) ? $clog2(nbeats) : 1;
  endfunction

endpackage

// File: rtl/umi_tx_serializer_if.sv
// Packet-in / beat-out handshake bundle around the serializer.
// master: the environment (packer side drives packets, link side drives ready).
// slave:  the serializer itself.
interface umi_tx_serializer_if
  import umi_tx_serializer_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int OW = OW_DEF
);

  logic          packet_valid;
  logic [PW-1:0] packet_in;
  logic          packet_ready;
  logic          beat_valid;
  logic [OW-1:0] beat_data;
  logic          beat_first;
  logic          beat_last;
  logic          beat_ready;
  logic          busy;

  modport master (
    output packet_valid, packet_in, beat_ready,
    input  packet_ready, beat_valid, beat_data, beat_first, beat_last, busy
  );

  modport slave (
    input  packet_valid, packet_in, beat_ready,
    output packet_ready, beat_valid, beat_data, beat_first, beat_last, busy
  );

endinterface

// File: rtl/umi_tx_serializer_beat_counter.sv
// Beat index counter shared with the receive-side deserializer.
// clear returns to beat 0; inc steps one beat but saturates at NBEATS-1,
// so the index can never leave 0..NBEATS-1.
module umi_tx_serializer_beat_counter #(
  parameter int NBEATS = 4,
  parameter int CW     = 2
) (
  input  logic clk,
  input  logic nreset,
  input  logic clear,
  input  logic inc,
  output logic first,
  output logic last
);

  logic [CW-1:0] cnt;

  // Beat index: clear has priority over increment.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (inc && !last)
      cnt <= cnt + CW'(1);
  end

  assign first = (cnt == '0);
  assign last  = (cnt == CW'(NBEATS - 1));

endmodule

// File: rtl/umi_tx_serializer.sv
// UMI transmit serializer: captures one PW-bit packet per handshake and
// emits it as NBEATS beats of OW bits, least-significant beat first.
// A new packet is accepted in the same cycle the last beat leaves, so
// back-to-back packets stream with no idle beat in between.
module umi_tx_serializer
  import umi_tx_serializer_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int PW = 4 * AW,
  parameter int OW = AW
) (
  input logic             clk,
  input logic             nreset,
  umi_tx_serializer_if.slave io
);

  localparam int NBEATS = PW / OW;
  localparam int CW     = cnt_width(NBEATS);

  // The packet must split into whole beats.
  if ((PW % OW) != 0 || NBEATS < 1) begin : g_bad_width
    $error("umi_tx_serializer: PW must be a non-zero multiple of OW");
  end

  state_t        state;
  logic [PW-1:0] shreg;
  logic          cnt_first;
  logic          cnt_last;
  logic          accept_in;
  logic          beat_adv;
  logic          last_adv;

  // Outputs are decoded from registered state only; in IDLE all flags are 0.
  assign io.beat_valid = (state == SEND);
  assign io.busy       = (state == SEND);
  assign io.beat_first = (state == SEND) && cnt_first;
  assign io.beat_last  = (state == SEND) && cnt_last;
  assign io.beat_data  = shreg[OW-1:0];

  // Ready depends only on state and downstream ready, never on packet_valid.
  assign io.packet_ready = (state == IDLE) || (io.beat_last && io.beat_ready);

  assign accept_in = io.packet_valid && io.packet_ready;
  assign beat_adv  = io.beat_valid && io.beat_ready;
  assign last_adv  = beat_adv && io.beat_last;

  // Restart at beat 0 on every load and when the final beat leaves.
  umi_tx_serializer_beat_counter #(
    .NBEATS (NBEATS),
    .CW     (CW)
  ) u_cnt (
    .clk    (clk),
    .nreset (nreset),
    .clear  (accept_in || last_adv),
    .inc    (beat_adv),
    .first  (cnt_first),
    .last   (cnt_last)
  );

  // FSM: go to SEND on a load, drop to IDLE only when the last beat leaves
  // without a replacement packet arriving in the same cycle.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (accept_in) state <= SEND;
        SEND:    if (last_adv && !accept_in) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  if (NBEATS > 1) begin : g_shift
    // Datapath: load a whole packet, then shift right one beat per accepted
    // non-final beat so the current beat always sits in the low OW bits.
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)
        shreg <= '0;
      else if (accept_in)
        shreg <= io.packet_in;
      else if (beat_adv && !io.beat_last)
        shreg <= {{OW{1'b0}}, shreg[PW-1:OW]};
    end
  end else begin : g_hold
    // Datapath: single-beat packets make this a plain pipeline register.
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)
        shreg <= '0;
      else if (accept_in)
        shreg <= io.packet_in;
    end
  end

endmodule

// File: tb/tb_umi_tx_serializer.sv
// Bench for umi_tx_serializer: a 4-beat instance (OW=64) and a 1-beat
// instance (OW=256). Expected beats are pushed to a scoreboard queue when a
// packet is accepted and popped when the DUT hands a beat to the link.
module tb_umi_tx_serializer;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  umi_tx_serializer_if #(.PW(256), .OW(64))  u4 ();
  umi_tx_serializer_if #(.PW(256), .OW(256)) u1 ();

  umi_tx_serializer #(.AW(64), .PW(256), .OW(64)) dut4 (
    .clk    (clk),
    .nreset (nreset),
    .io     (u4)
  );

  umi_tx_serializer #(.AW(64), .PW(256), .OW(256)) dut1 (
    .clk    (clk),
    .nreset (nreset),
    .io     (u1)
  );

  typedef struct packed {
    logic [63:0] d;
    logic        f;
    logic        l;
  } exp4_t;

  exp4_t        q4[$];
  logic [255:0] q1[$];

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Model: a packet becomes four beats, low 64 bits first.
  function automatic void push4(input logic [255:0] p);
    for (int k = 0; k < 4; k++) q4.push_back('{d: p[64*k +: 64], f: (k == 0), l: (k == 3)});
  endfunction

  task automatic test_reset();
    nreset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      u4.packet_valid = 1'($urandom); u4.packet_in = rand256(); u4.beat_ready = 1'($urandom);
      u1.packet_valid = 1'($urandom); u1.packet_in = rand256(); u1.beat_ready = 1'($urandom);
      #1;
      n_checks++;
      if ({u4.beat_valid, u4.busy, u4.beat_first, u4.beat_last} !== 4'b0000)
        $display("FAIL reset_flags4: got %b expected 0000", {u4.beat_valid, u4.busy, u4.beat_first, u4.beat_last});
      else n_pass++;
      n_checks++;
      if (u4.beat_data !== 64'd0) $display("FAIL reset_data4: got %h expected 0", u4.beat_data);
      else n_pass++;
      n_checks++;
      if ({u1.beat_valid, u1.busy, u1.beat_first, u1.beat_last} !== 4'b0000)
        $display("FAIL reset_flags1: got %b expected 0000", {u1.beat_valid, u1.busy, u1.beat_first, u1.beat_last});
      else n_pass++;
    end
    @(negedge clk);
    nreset = 1'b1;
    u4.packet_valid = 1'b0; u4.beat_ready = 1'b0;
    u1.packet_valid = 1'b0; u1.beat_ready = 1'b0;
    #1;
    n_checks++;
    if ({u4.packet_ready, u4.beat_valid, u4.busy} !== 3'b100)
      $display("FAIL reset_release4: got rdy/vld/busy %b expected 100", {u4.packet_ready, u4.beat_valid, u4.busy});
    else n_pass++;
    n_checks++;
    if ({u1.packet_ready, u1.beat_valid, u1.busy} !== 3'b100)
      $display("FAIL reset_release1: got rdy/vld/busy %b expected 100", {u1.packet_ready, u1.beat_valid, u1.busy});
    else n_pass++;
  endtask

  task automatic test_single();
    logic [255:0] p;
    exp4_t        e;
    int           acc_c, nb;
    p = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    acc_c = -100; nb = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      u4.packet_valid = (c == 0); u4.packet_in = p; u4.beat_ready = 1'b1;
      #1;
      if (u4.packet_valid && u4.packet_ready) begin acc_c = c; push4(p); end
      if (u4.beat_valid && u4.beat_ready) begin
        n_checks++;
        if (q4.size() == 0) $display("FAIL single_extra: got beat %h expected none", u4.beat_data);
        else begin
          e = q4.pop_front();
          if ({u4.beat_data, u4.beat_first, u4.beat_last} !== {e.d, e.f, e.l})
            $display("FAIL single_beat: got %h f%b l%b expected %h f%b l%b",
                     u4.beat_data, u4.beat_first, u4.beat_last, e.d, e.f, e.l);
          else n_pass++;
        end
        n_checks++;
        if (c !== acc_c + 1 + nb) $display("FAIL single_timing: got cycle %0d expected %0d", c, acc_c + 1 + nb);
        else n_pass++;
        nb++;
      end
    end
    n_checks++;
    if (nb !== 4) $display("FAIL single_count: got %0d beats expected 4", nb);
    else n_pass++;
    n_checks++;
    if ({u4.beat_valid, u4.busy, u4.packet_ready} !== 3'b001 || q4.size() != 0)
      $display("FAIL single_idle: got vld/busy/rdy %b pending %0d expected 001 pending 0",
               {u4.beat_valid, u4.busy, u4.packet_ready}, q4.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [255:0] pk[3];
    exp4_t        e;
    logic         exp_pr;
    int           sent, nb, first_c, last_c;
    for (int i = 0; i < 3; i++) pk[i] = rand256();
    sent = 0; nb = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      u4.packet_valid = (sent < 3); u4.packet_in = pk[(sent < 3) ? sent : 2]; u4.beat_ready = 1'b1;
      #1;
      exp_pr = (q4.size() == 0) ? 1'b1 : q4[0].l;
      n_checks++;
      if (u4.packet_ready !== exp_pr) $display("FAIL b2b_ready: cycle %0d got %b expected %b", c, u4.packet_ready, exp_pr);
      else n_pass++;
      if (u4.packet_valid && u4.packet_ready) begin push4(u4.packet_in); sent++; end
      if (u4.beat_valid && u4.beat_ready) begin
        n_checks++;
        if (q4.size() == 0) $display("FAIL b2b_extra: got beat %h expected none", u4.beat_data);
        else begin
          e = q4.pop_front();
          if ({u4.beat_data, u4.beat_first, u4.beat_last} !== {e.d, e.f, e.l})
            $display("FAIL b2b_beat: got %h f%b l%b expected %h f%b l%b",
                     u4.beat_data, u4.beat_first, u4.beat_last, e.d, e.f, e.l);
          else n_pass++;
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        nb++;
      end
    end
    n_checks++;
    if (nb !== 12 || last_c - first_c !== 11)
      $display("FAIL b2b_stream: got %0d beats over %0d cycles expected 12 over 11", nb, last_c - first_c);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [255:0] pk[2];
    exp4_t        e;
    logic         exp_pr;
    int           sent, nb;
    for (int i = 0; i < 2; i++) pk[i] = rand256();
    sent = 0; nb = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      u4.packet_valid = (sent < 2); u4.packet_in = pk[(sent < 2) ? sent : 1];
      u4.beat_ready = ((c % 3) == 0);
      #1;
      exp_pr = (q4.size() == 0) ? 1'b1 : (q4[0].l && u4.beat_ready);
      n_checks++;
      if (u4.packet_ready !== exp_pr) $display("FAIL bp_ready: cycle %0d got %b expected %b", c, u4.packet_ready, exp_pr);
      else n_pass++;
      n_checks++;
      if (u4.busy !== (q4.size() != 0)) $display("FAIL bp_busy: cycle %0d got %b expected %b", c, u4.busy, q4.size() != 0);
      else n_pass++;
      // Whether stalled or not, the offered beat must be the oldest expected one.
      if (u4.beat_valid) begin
        n_checks++;
        if (q4.size() == 0) $display("FAIL bp_extra: got beat %h expected none", u4.beat_data);
        else if ({u4.beat_data, u4.beat_first, u4.beat_last} !== {q4[0].d, q4[0].f, q4[0].l})
          $display("FAIL bp_beat: cycle %0d got %h f%b l%b expected %h f%b l%b", c,
                   u4.beat_data, u4.beat_first, u4.beat_last, q4[0].d, q4[0].f, q4[0].l);
        else n_pass++;
      end
      if (u4.packet_valid && u4.packet_ready) begin push4(u4.packet_in); sent++; end
      if (u4.beat_valid && u4.beat_ready && q4.size() != 0) begin e = q4.pop_front(); nb++; end
    end
    n_checks++;
    if (nb !== 8 || q4.size() != 0) $display("FAIL bp_count: got %0d beats pending %0d expected 8 pending 0", nb, q4.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [255:0] p;
    exp4_t        e;
    int           nb;
    logic         done;
    p = rand256(); nb = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      u4.packet_valid = (c == 0); u4.packet_in = p; u4.beat_ready = 1'b1;
      #1;
      if (u4.packet_valid && u4.packet_ready) push4(p);
      if (u4.beat_valid && u4.beat_ready && q4.size() != 0) begin e = q4.pop_front(); nb++; end
      if (nb == 2) done = 1'b1;
    end
    @(negedge clk);
    u4.beat_ready = 1'b0;
    #1;
    n_checks++;
    if (q4.size() == 0 || {u4.beat_valid, u4.beat_first, u4.beat_data} !== {1'b1, 1'b0, q4[0].d})
      $display("FAIL mid_beat2: got vld%b f%b %h expected beat 2 of packet", u4.beat_valid, u4.beat_first, u4.beat_data);
    else n_pass++;
    #1 nreset = 1'b0;
    #1;
    n_checks++;
    if ({u4.beat_valid, u4.busy, u4.beat_first, u4.beat_last, u4.packet_ready} !== 5'b00001)
      $display("FAIL mid_async: got vld/busy/f/l/rdy %b expected 00001",
               {u4.beat_valid, u4.busy, u4.beat_first, u4.beat_last, u4.packet_ready});
    else n_pass++;
    n_checks++;
    if (u4.beat_data !== 64'd0) $display("FAIL mid_data: got %h expected 0", u4.beat_data);
    else n_pass++;
    q4.delete();
    @(negedge clk);
    nreset = 1'b1;
    p = rand256(); nb = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      u4.packet_valid = (c == 0); u4.packet_in = p; u4.beat_ready = 1'b1;
      #1;
      if (u4.packet_valid && u4.packet_ready) push4(p);
      if (u4.beat_valid && nb == 0) begin
        n_checks++;
        if (u4.beat_first !== 1'b1) $display("FAIL mid_first: got %b expected 1", u4.beat_first);
        else n_pass++;
      end
      if (u4.beat_valid && u4.beat_ready) begin
        n_checks++;
        if (q4.size() == 0) $display("FAIL mid_extra: got beat %h expected none", u4.beat_data);
        else begin
          e = q4.pop_front();
          if ({u4.beat_data, u4.beat_first, u4.beat_last} !== {e.d, e.f, e.l})
            $display("FAIL mid_beat: got %h f%b l%b expected %h f%b l%b",
                     u4.beat_data, u4.beat_first, u4.beat_last, e.d, e.f, e.l);
          else n_pass++;
        end
        nb++;
      end
    end
    n_checks++;
    if (nb !== 4) $display("FAIL mid_count: got %0d beats expected 4", nb);
    else n_pass++;
  endtask

  task automatic test_single_beat();
    logic [255:0] pk[16];
    logic [255:0] e;
    logic         exp_pr;
    int           sent, nb, first_c, last_c;
    for (int i = 0; i < 16; i++) pk[i] = rand256();
    sent = 0; nb = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 300 && nb < 16; c++) begin
      @(negedge clk);
      u1.packet_valid = (sent < 16); u1.packet_in = pk[(sent < 16) ? sent : 15];
      u1.beat_ready = (nb < 8) ? 1'($urandom) : 1'b1;
      #1;
      exp_pr = (q1.size() == 0) || u1.beat_ready;
      n_checks++;
      if (u1.packet_ready !== exp_pr) $display("FAIL nb1_ready: cycle %0d got %b expected %b", c, u1.packet_ready, exp_pr);
      else n_pass++;
      if (u1.beat_valid) begin
        n_checks++;
        if ({u1.beat_first, u1.beat_last} !== 2'b11) $display("FAIL nb1_flags: got %b expected 11", {u1.beat_first, u1.beat_last});
        else n_pass++;
      end
      if (u1.packet_valid && u1.packet_ready) begin q1.push_back(u1.packet_in); sent++; end
      if (u1.beat_valid && u1.beat_ready) begin
        n_checks++;
        if (q1.size() == 0) $display("FAIL nb1_extra: got beat %h expected none", u1.beat_data);
        else begin
          e = q1.pop_front();
          if (u1.beat_data !== e) $display("FAIL nb1_beat: got %h expected %h", u1.beat_data, e);
          else n_pass++;
        end
        if (nb == 8) first_c = c;
        if (nb == 15) last_c = c;
        nb++;
      end
    end
    n_checks++;
    if (nb !== 16 || last_c - first_c !== 7)
      $display("FAIL nb1_throughput: got %0d beats, last 8 over %0d cycles expected 16 over 7", nb, last_c - first_c);
    else n_pass++;
  endtask

  initial begin
    u4.packet_valid = 1'b0; u4.packet_in = '0; u4.beat_ready = 1'b0;
    u1.packet_valid = 1'b0; u1.packet_in = '0; u1.beat_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_single_beat();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
